// File: rtl/voice_synth.sv
// voice_synth: 8-voice time-multiplexed oscillator bank and mixer.
//
// A sample_tick in IDLE starts one sample. The design then spends one RUN
// cycle per voice (0..7) and one DONE cycle, so the result appears 10 cycles
// after the tick. Each voice is a 32-bit phase accumulator that produces a
// sawtooth. The waveform is scaled by a gain taken from the envelope volume,
// and the eight products are summed in a 19-bit signed accumulator. The
// output sample is that sum divided by 8.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   sample_tick    one-cycle strobe requesting a new sample
//   frequencies    8 x 16-bit per-voice frequency, Q11.5, unsigned
//   voice_volumes  8 x 32-bit per-voice volume, signed, full scale 2^20
//   wave_sel       8 x 1-bit square/saw select (SQUARE_WAVE_EN builds only)
//   sample_out     signed mixed sample, held between valid pulses
//   sample_valid   one-cycle pulse when sample_out updates
//   overrun        sticky; set when a tick arrives outside IDLE
//
// Build option: define SQUARE_WAVE_EN to add wave_sel. When a voice's bit is
// set, that voice plays a square wave instead of a sawtooth.

// Per-voice phase accumulator. It advances only on its own RUN slot.
module voice_synth_lane #(
    parameter int unsigned PHASE_K = 2796
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    input  logic        silent,
    input  logic [15:0] freq,
    output logic [15:0] phase_hi
);
    logic [31:0] phase;

    assign phase_hi = phase[31:16];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            phase <= '0;
        else if (step)
            // A silent voice restarts from phase 0, so it re-enters at -full scale.
            phase <= silent ? 32'd0 : phase + 32'(freq) * PHASE_K;
    end
endmodule

module voice_synth #(
    parameter int unsigned PHASE_K   = 2796,
    parameter int unsigned VOL_SHIFT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_tick,
    input  logic [7:0][15:0]    frequencies,
    input  logic [7:0][31:0]    voice_volumes,
`ifdef SQUARE_WAVE_EN
    input  logic [7:0]          wave_sel,
`endif
    output logic signed [15:0]  sample_out,
    output logic                sample_valid,
    output logic                overrun
);
    localparam int NUM_VOICES = 8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         idx;
    logic signed [18:0] acc;

    logic [NUM_VOICES-1:0][15:0] phase_hi;
    logic [15:0]                 freq_v;
    logic [31:0]                 vol_v;
    logic [31:0]                 vol_shr;
    logic [15:0]                 gain;
    logic                        silent;
    logic signed [15:0]          wave;
    logic signed [16:0]          gain_s;
    logic signed [32:0]          prod;
    logic signed [16:0]          contrib;

    // Inputs are read live in the current voice slot. No snapshot is taken.
    assign freq_v  = frequencies[idx];
    assign vol_v   = voice_volumes[idx];
    assign vol_shr = vol_v >> VOL_SHIFT;

    always_comb begin
        gain = vol_shr[15:0];
        if (vol_v[31])
            gain = 16'd0;
        else if (vol_v >= 32'h0010_0000 || vol_shr > 32'd65535)
            gain = 16'hFFFF;
    end

    assign silent = (freq_v == 16'd0) || (gain == 16'd0);

    // Inverting the phase MSB maps phase 0 to -32768. This gives a
    // rising two's-complement ramp.
    always_comb begin
        wave = {~phase_hi[idx][15], phase_hi[idx][14:0]};
`ifdef SQUARE_WAVE_EN
        if (wave_sel[idx])
            wave = phase_hi[idx][15] ? 16'sh7FFF : 16'sh8000;
`endif
    end

    // Gain is unsigned. Zero-extending it to 17 bits keeps the product signed.
    // The arithmetic shift floors toward minus infinity.
    assign gain_s  = {1'b0, gain};
    assign prod    = wave * gain_s;
    assign contrib = silent ? 17'sd0 : 17'(prod >>> 16);

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_lane
        voice_synth_lane #(.PHASE_K(PHASE_K)) u_lane (
            .clk      (clk),
            .reset    (reset),
            .step     (state_q == RUN && idx == 3'(i)),
            .silent   (silent),
            .freq     (frequencies[i]),
            .phase_hi (phase_hi[i])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sample_tick) state_d = RUN;
            RUN:     if (idx == 3'd7) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc          <= '0;
            idx          <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            // A tick in DONE is also dropped, because the FSM only
            // returns to IDLE after this cycle.
            if (sample_tick && state_q != IDLE)
                overrun <= 1'b1;
            case (state_q)
                IDLE: if (sample_tick) begin
                    acc <= '0;
                    idx <= '0;
                end
                RUN: begin
                    acc <= acc + {{2{contrib[16]}}, contrib};
                    idx <= idx + 3'd1;
                end
                DONE: begin
                    // The worst-case sum of eight terms is 8 * -32768, which
                    // fits in 19 bits, so the divide by 8 cannot overflow.
                    sample_out   <= 16'(acc >>> 3);
                    sample_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_voice_synth.sv
// Directed bench for voice_synth. The stimulus pushes hand-computed expected
// samples into a queue, and a negedge monitor pops one entry and compares it
// on every sample_valid pulse.
module tb_voice_synth;
    logic                clk = 1'b0;
    logic                reset;
    logic                sample_tick;
    logic [7:0][15:0]    frequencies;
    logic [7:0][31:0]    voice_volumes;
`ifdef SQUARE_WAVE_EN
    logic [7:0]          wave_sel;
`endif
    logic signed [15:0]  sample_out;
    logic                sample_valid;
    logic                overrun;

    int checks = 0;
    int errors = 0;
    logic signed [15:0] exp_q[$];

    always #5 clk = ~clk;

    voice_synth dut (
        .clk           (clk),
        .reset         (reset),
        .sample_tick   (sample_tick),
        .frequencies   (frequencies),
        .voice_volumes (voice_volumes),
`ifdef SQUARE_WAVE_EN
        .wave_sel      (wave_sel),
`endif
        .sample_out    (sample_out),
        .sample_valid  (sample_valid),
        .overrun       (overrun)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && sample_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got sample %0d, expected no pulse", sample_out);
            end else begin
                check("sample", int'(sample_out), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic clear_voices();
        frequencies   = '0;
        voice_volumes = '0;
    endtask

    task automatic set_voice(input int v, input int f, input int vol);
        frequencies[v]   = 16'(f);
        voice_volumes[v] = 32'(vol);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // One tick, then a check that the valid pulse lands exactly at T+10.
    task automatic run_sample(input logic signed [15:0] exp);
        @(posedge clk); #1 sample_tick = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1 sample_tick = 1'b0;
        repeat (8) @(posedge clk);
        #1 check("valid_early", int'(sample_valid), 0);
        @(posedge clk);
        #1 check("valid_at_T10", int'(sample_valid), 1);
        @(posedge clk);
        #1 check("valid_one_cycle", int'(sample_valid), 0);
    endtask

    initial begin
        reset = 1'b1;
        sample_tick = 1'b0;
        clear_voices();
`ifdef SQUARE_WAVE_EN
        wave_sel = '0;
`endif
        @(posedge clk); #1;
        check("reset_sample_out", int'(sample_out), 0);
        check("reset_valid", int'(sample_valid), 0);
        check("reset_overrun", int'(overrun), 0);
        @(posedge clk); #1 reset = 1'b0;

        // All inputs zero: the output is silent and the phases stay at 0.
        run_sample(16'sd0);
        check("zero_overrun", int'(overrun), 0);
        set_voice(0, 1760, 32'h0010_0000);
        run_sample(-16'sd4096);

        // 55 Hz voice at full scale, ticks 20 cycles apart.
        do_reset();
        run_sample(-16'sd4096);
        repeat (9) @(posedge clk);
        run_sample(-16'sd4087);
        run_sample(-16'sd4078);
        // Gain 0 from vol 15 silences the voice and rewinds the phase.
        set_voice(0, 1760, 15);
        run_sample(16'sd0);
        set_voice(0, 1760, 32'h0010_0000);
        run_sample(-16'sd4096);
        // A frequency of 0 is also silent.
        set_voice(0, 0, 32'h0010_0000);
        run_sample(16'sd0);

        // Negative volume gives gain 0 with the phase held. A huge volume clamps to 65535.
        do_reset();
        set_voice(0, 1760, -5);
        run_sample(16'sd0);
        set_voice(0, 1760, 32'h0200_0000);
        run_sample(-16'sd4096);

        // Gain 1: -32768*1 >>> 16 = -1 (floor), then -1 >>> 3 = -1.
        do_reset();
        set_voice(0, 1760, 16);
        run_sample(-16'sd1);

        // Mixed voices: -32768 - 16384 + 0 - 32768 = -81920, and /8 = -10240.
        do_reset();
        clear_voices();
        set_voice(0, 100, 32'h0010_0000);
        set_voice(1, 100, 32'h0008_0000);
        set_voice(2, 100, -1);
        set_voice(3, 100, 32'h0100_0000);
        run_sample(-16'sd10240);

        // All eight voices at -full scale gives the most negative sample.
        do_reset();
        for (int v = 0; v < 8; v++) set_voice(v, 1760, 32'h0010_0000);
        run_sample(-16'sd32768);

        // Second tick 4 cycles into RUN: one pulse only, and overrun becomes sticky.
        do_reset();
        clear_voices();
        set_voice(0, 1760, 32'h0010_0000);
        @(posedge clk); #1 sample_tick = 1'b1;
        exp_q.push_back(-16'sd4096);
        @(posedge clk); #1 sample_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        check("overrun_set", int'(overrun), 1);
        repeat (4) @(posedge clk);
        #1 check("ovr_valid_early", int'(sample_valid), 0);
        @(posedge clk);
        #1 check("ovr_valid_at_T10", int'(sample_valid), 1);
        repeat (12) @(posedge clk);
        run_sample(-16'sd4087);
        check("overrun_sticky", int'(overrun), 1);
        do_reset();
        check("overrun_cleared", int'(overrun), 0);

        // Tick during the DONE cycle is dropped and flags overrun.
        run_sample(-16'sd4096);
        @(posedge clk); #1 sample_tick = 1'b1;
        exp_q.push_back(-16'sd4087);
        @(posedge clk); #1 sample_tick = 1'b0;
        repeat (8) @(posedge clk);
        #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        check("done_tick_valid", int'(sample_valid), 1);
        repeat (12) @(posedge clk);
        #1 check("done_tick_overrun", int'(overrun), 1);

        // Reset during RUN abandons the sample, zeroes the output and rewinds the phases.
        do_reset();
        run_sample(-16'sd4096);
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1 check("midrun_sample_out", int'(sample_out), 0);
        check("midrun_valid", int'(sample_valid), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (12) @(posedge clk);
        #1 check("midrun_hold", int'(sample_out), 0);
        run_sample(-16'sd4096);

`ifdef SQUARE_WAVE_EN
        // Square wave on voice 0: phase step 183235860, so phase[31] sets after 12 steps.
        do_reset();
        clear_voices();
        wave_sel = 8'h01;
        set_voice(0, 65535, 32'h0010_0000);
        for (int k = 0; k < 12; k++) run_sample(-16'sd4096);
        run_sample(16'sd4095);
`endif

        repeat (3) @(posedge clk);
        #1 check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/voice_synth.md
Name: voice_synth

Overview:
- Downstream of the keyboard voice allocator.
- Consumes the 8 per-voice note frequencies (Hz, Q11.5 fixed point) and the 8 per-voice envelope volumes.
- Produces one mixed 16-bit signed audio sample per sample tick, using a time-multiplexed phase-accumulator sawtooth oscillator, per-voice gain scaling and an 8-way sum.
- Feeds the audio output/DAC stage.

Parameters:
- PHASE_K, 2796, phase increment per Q11.5 frequency unit: 2^32/(Fs*32) for Fs = 48 kHz.
- VOL_SHIFT, 4, right shift applied to the clamped volume to form the 16-bit gain.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sample_tick  in  1  one-cycle strobe requesting a new sample
- frequencies[7:0]  in  16 each  per-voice frequency, Q11.5, treated as unsigned
- voice_volumes[7:0]  in  32 each  per-voice volume, signed; full scale 2^20
- sample_out  out  16  signed mixed sample
- sample_valid  out  1  one-cycle pulse when sample_out updates
- overrun  out  1  sticky: a tick arrived while busy

Behaviour:
- Reset (async, active-high) clears:
  - sample_out = 0, sample_valid = 0, overrun = 0
  - all 8 phase accumulators (32-bit) = 0
  - accumulator = 0, voice index = 0, state = IDLE
- Reset mid-RUN abandons the sample; no valid pulse is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - sample_tick = 1 → clear accumulator (19-bit signed), index = 0, go to RUN.
- RUN, one voice per cycle (index v = 0..7):
  - gain:
    - vol < 0 → 0
    - vol ≥ 2^20 → 65535
    - otherwise (vol >> VOL_SHIFT), saturated to 65535
  - saw = {~phase[v][31], phase[v][30:16]} as signed 16 (phase 0 maps to −32768).
  - Silent voice (freq == 0 or gain == 0): contribution 0; phase[v] <= 0.
  - Otherwise:
    - contribution = (saw * gain) >>> 16, arithmetic shift, floor.
    - phase[v] <= phase[v] + freq*PHASE_K (32-bit product, wraps mod 2^32).
  - acc <= acc + contribution, using the pre-update phase.
  - v == 7 → DONE; else v+1.
- DONE:
  - sample_out <= acc >>> 3. No saturation is needed: the 8-term sum fits 19 bits.
  - sample_valid <= 1 for exactly this one cycle, then IDLE.
- Latency: tick at cycle T → sample_valid high and sample_out updated at T+10 (RUN T+1..T+8, DONE registered T+9, visible T+10).
- Minimum tick spacing is 10 cycles.
- Inputs are sampled live during RUN; no input snapshot is taken.
- sample_tick in RUN or DONE: ignored, overrun <= 1. overrun clears only on reset.
- sample_tick in the same cycle as DONE → IDLE: ignored, overrun set.
- sample_out holds its value between valid pulses.

Optional Feature:
- SQUARE_WAVE_EN defined:
  - Adds input wave_sel[7:0] (1 bit per voice).
  - Bit set → the voice uses a square wave: +32767 when phase[31] = 1, else −32768, in place of saw.
  - Gain, silence and phase rules are unchanged.
- SQUARE_WAVE_EN undefined:
  - Port absent; all voices use sawtooth.

Test Plan:
- Reset, then tick with all inputs 0 → sample_out = 0, valid pulse at T+10, all phases remain 0, overrun = 0.
- Voice0 freq = 1760 (55 Hz), vol = 2^20, others silent; two ticks 20 cycles apart:
  - first sample_out = −4096
  - phase0 = 4920960
  - second sample_out = −4087
- Voice0 vol = −5, then vol = 2^25, freq = 1760 → first sample 0 with phase0 held at 0; next gain clamps to 65535 and sample = −4096.
- Tick, then second tick 4 cycles later → single valid pulse at T+10, overrun = 1 stays set until reset.
- Assert reset during RUN (cycle T+5) → sample_out = 0, valid never pulses, next tick gives a normal result at +10.
- With SQUARE_WAVE_EN, wave_sel[0] = 1, voice0 vol = 2^20, freq = 1760 → first sample (phase 0) = −4096; after phase0 ≥ 2^31, sample = 4095.
